// File: rtl/change_pkg.sv
// Shared definitions for the word splitter: FSM state encoding and widths.
//   GAP_W  : width of the inter-word gap down-counter
//   BYTE_W : width of one transmitted byte
package change_pkg;

  localparam int GAP_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_H = 2'd1,
    SEND_L = 2'd2,
    GAP    = 2'd3
  } state_e;

endpackage

// File: rtl/word_hold_buf.sv
// One-entry hold buffer between the word handshake and the splitter FSM.
//   clk, rst  : clock, synchronous active-high reset
//   push      : store push_data (only issued while empty)
//   push_data : word to store
//   pop       : release the stored word (only issued while full)
//   data      : stored word
//   full      : buffer holds a word
module word_hold_buf
  import change_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [2*BYTE_W-1:0]   push_data,
  input  logic                  pop,
  output logic [2*BYTE_W-1:0]   data,
  output logic                  full
);

  logic                full_q, full_d;
  logic [2*BYTE_W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (pop) full_d = 1'b0;
    if (push) begin
      full_d = 1'b1;
      data_d = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign data = data_q;
  assign full = full_q;

endmodule

// File: rtl/word_split_tx.sv
// Splits 16-bit words into an H byte then an L byte, each held until the
// downstream accepts it, with GAP_CYCLES idle cycles after every L byte.
//   clk, rst            : clock, synchronous active-high reset
//   word_in/valid/ready : word handshake into a one-entry hold buffer
//   out_ready           : downstream takes the presented byte
//   H, h_stb            : high byte and its strobe (zero outside SEND_H)
//   L, l_stb            : low byte and its strobe (zero outside SEND_L)
//   busy                : word buffered or in flight
//   word_cnt            : completed words, modulo 256
//
// state  | meaning
// IDLE   | nothing in flight, waiting for the buffer to fill
// SEND_H | presenting tx[15:8] until out_ready
// SEND_L | presenting tx[7:0] until out_ready
// GAP    | idle spacing after an L byte, GAP_CYCLES long
module word_split_tx
  import change_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*BYTE_W-1:0] word_in,
  input  logic                word_valid,
  output logic                word_ready,
  input  logic                out_ready,
  output logic [BYTE_W-1:0]   H,
  output logic [BYTE_W-1:0]   L,
  output logic                h_stb,
  output logic                l_stb,
  output logic                busy,
  output logic [7:0]          word_cnt
);

  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
  // Gap counter is loaded with the last index and counts down to zero.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [2*BYTE_W-1:0] tx_q, tx_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [BYTE_W-1:0]   h_q, h_d, l_q, l_d;
  logic                hs_q, hs_d, ls_q, ls_d;

  logic                buf_push, buf_pop, buf_full, take;
  logic [2*BYTE_W-1:0] buf_data;

  word_hold_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (word_in),
    .pop       (buf_pop),
    .data      (buf_data),
    .full      (buf_full)
  );

  // rst gates ready so nothing is accepted on a reset edge.
  assign word_ready = ~buf_full & ~rst;
  assign buf_push   = word_valid & word_ready;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      IDLE:   take = buf_full;
      SEND_H: if (out_ready) state_d = SEND_L;
      SEND_L: begin
        if (out_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (HAS_GAP) begin
            state_d = GAP;
            gap_d   = GAP_LAST;
          end else if (buf_full) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          if (buf_full) take = 1'b1;
          else          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Loading the next word empties the buffer on the same edge.
    buf_pop = take;
    if (take) begin
      state_d = SEND_H;
      tx_d    = buf_data;
    end
    // Outputs are registered from the next state so they line up with it.
    hs_d = (state_d == SEND_H);
    ls_d = (state_d == SEND_L);
    h_d  = hs_d ? tx_d[2*BYTE_W-1:BYTE_W] : '0;
    l_d  = ls_d ? tx_d[BYTE_W-1:0]        : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      h_q     <= '0;
      l_q     <= '0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      l_q     <= l_d;
      hs_q    <= hs_d;
      ls_q    <= ls_d;
    end
  end

  assign H        = h_q;
  assign L        = l_q;
  assign h_stb    = hs_q;
  assign l_stb    = ls_q;
  assign busy     = (state_q != IDLE) | buf_full;
  assign word_cnt = cnt_q;

endmodule
